tone_timer_ctrl: RTL

//  Parametrised front-panel tone controller: debounces NUM_SEL tone-select buttons plus a stop button,

---
 rtl/tone_timer_ctrl_if.sv | 33 +++
 rtl/tone_timer_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_timer_ctrl_if.sv
// Front-panel signal bundle for tone_timer_ctrl: raw pushbuttons in,
// buzzer / LED / 1 Hz outputs back to the board.
interface tone_timer_ctrl_if #(
   parameter int NUM_SEL = 3,
   parameter int SEL_W   = 2
);
   logic [NUM_SEL-1:0] freq;
   logic               reset_button;
   logic               clk_1Hz;
   logic               buzzer;
   logic               active;
   logic [SEL_W-1:0]   tone_sel;

   // Board/panel side: drives the buttons, observes the outputs
   modport master (
      output freq,
      output reset_button,
      input  clk_1Hz,
      input  buzzer,
      input  active,
      input  tone_sel
   );

   // Controller side
   modport slave (
      input  freq,
      input  reset_button,
      output clk_1Hz,
      output buzzer,
      output active,
      output tone_sel
   );
endinterface

// File: rtl/tone_timer_ctrl.sv
// Front-panel tone controller: debounces NUM_SEL tone buttons plus a stop
// button, runs an IDLE/RUN machine and drives a buzzer square wave whose
// half-period is TONE_HALF_BASE >> tone_sel. A free-running 1 Hz square wave
// is produced alongside and can gate the tone when BEEP_MODE = 1.
module tone_timer_ctrl #(
   parameter int CLK_HZ         = 50_000_000,
   parameter int NUM_SEL        = 3,
   parameter int SEL_W          = 2,
   parameter int DB_CYCLES      = 1_000_000,
   parameter int TONE_HALF_BASE = 25_000,
   parameter int BEEP_MODE      = 0
) (
   input  logic             clk_50MHz,
   input  logic             reset,
   tone_timer_ctrl_if.slave bus
);

   localparam int NB   = NUM_SEL + 1;
   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int TC_W = $clog2(TONE_HALF_BASE + 1);
   localparam int HZ_W = $clog2(CLK_HZ / 2 + 1);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [TC_W-1:0] HALF_BASE = TC_W'(TONE_HALF_BASE);
   localparam logic [HZ_W-1:0] HZ_LAST   = HZ_W'(CLK_HZ / 2 - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Button path: bit NUM_SEL is the stop button, lower bits are tone selects
   logic [NB-1:0]    w_raw;
   logic [NB-1:0]    r_sync1;
   logic [NB-1:0]    r_sync2;
   logic [NB-1:0]    r_deb;
   logic [NB-1:0]    r_deb_q;
   logic [NB-1:0]    r_press;
   logic [DB_W-1:0]  r_db_cnt [NB];

   // Control
   state_t           r_state;
   state_t           w_state_next;
   logic [SEL_W-1:0] r_tone_sel;
   logic [SEL_W-1:0] w_sel_next;
   logic             w_load;
   logic             w_stop;
   logic             w_pick_vld;
   logic [SEL_W-1:0] w_pick;

   // Tone and 1 Hz generators
   logic [TC_W-1:0]  r_tc;
   logic [TC_W-1:0]  w_tc_next;
   logic [TC_W-1:0]  w_half_last;
   logic             r_sq;
   logic             w_sq_next;
   logic             w_run_next;
   logic             w_tone_rst;
   logic [HZ_W-1:0]  r_hz_cnt;
   logic [HZ_W-1:0]  w_hz_next;
   logic             r_clk_1hz;
   logic             w_clk_1hz_next;
   logic             w_beep_gate;
   logic             r_buzzer;

   assign w_raw  = {bus.reset_button, bus.freq};
   assign w_stop = r_press[NUM_SEL];

   // Two-flop synchroniser for every raw button
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: accept a new level only after DB_CYCLES consecutive differing samples
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         r_deb <= '0;
         for (int unsigned i = 0; i < NB; i++) begin
            r_db_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_deb[i]    <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // One-cycle press pulse on each debounced rising edge
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         r_deb_q <= '0;
         r_press <= '0;
      end else begin
         r_deb_q <= r_deb;
         r_press <= r_deb & ~r_deb_q;
      end
   end

   // Lowest-index tone-select press wins
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick     = '0;
      for (int unsigned i = 0; i < NUM_SEL; i++) begin
         if (r_press[i] && !w_pick_vld) begin
            w_pick_vld = 1'b1;
            w_pick     = SEL_W'(i);
         end
      end
   end

   // Next state: stop beats any select; re-pressing the running tone turns it off
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_tone_sel;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_stop && w_pick_vld) begin
               w_state_next = S_RUN;
               w_sel_next   = w_pick;
               w_load       = 1'b1;
            end
         end
         S_RUN: begin
            if (w_stop) begin
               w_state_next = S_IDLE;
            end else if (w_pick_vld) begin
               if (w_pick == r_tone_sel) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_sel_next = w_pick;
                  w_load     = 1'b1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State and selected-tone registers
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_tone_sel <= '0;
      end else begin
         r_state    <= w_state_next;
         r_tone_sel <= w_sel_next;
      end
   end

   // Tone and 1 Hz next values; the tone restarts whenever it is idle or (re)loaded
   always_comb begin
      w_run_next  = (w_state_next == S_RUN);
      w_tone_rst  = !w_run_next || w_load;
      w_half_last = (HALF_BASE >> r_tone_sel) - TC_W'(1);
      w_tc_next   = r_tc + TC_W'(1);
      w_sq_next   = r_sq;
      if (w_tone_rst) begin
         w_tc_next = '0;
         w_sq_next = 1'b0;
      end else if (r_tc == w_half_last) begin
         w_tc_next = '0;
         w_sq_next = ~r_sq;
      end

      w_hz_next      = r_hz_cnt + HZ_W'(1);
      w_clk_1hz_next = r_clk_1hz;
      if (r_hz_cnt == HZ_LAST) begin
         w_hz_next      = '0;
         w_clk_1hz_next = ~r_clk_1hz;
      end

      w_beep_gate = (BEEP_MODE != 0) ? w_clk_1hz_next : 1'b1;
   end

   // Generator registers; buzzer is built from next values so it aligns with sq
   always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
         r_tc      <= '0;
         r_sq      <= 1'b0;
         r_hz_cnt  <= '0;
         r_clk_1hz <= 1'b0;
         r_buzzer  <= 1'b0;
      end else begin
         r_tc      <= w_tc_next;
         r_sq      <= w_sq_next;
         r_hz_cnt  <= w_hz_next;
         r_clk_1hz <= w_clk_1hz_next;
         r_buzzer  <= w_sq_next & w_run_next & w_beep_gate;
      end
   end

   assign bus.clk_1Hz  = r_clk_1hz;
   assign bus.buzzer   = r_buzzer;
   assign bus.active   = (r_state == S_RUN);
   assign bus.tone_sel = r_tone_sel;

endmodule
